// File: rtl/defines_pkg.sv
// Shared constants and helpers for the mac_vec dot-product datapath.
package defines_pkg;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ACC_W       = 2 * DEF_DATA_W;
    localparam int DEF_VEC_MAX     = 16;
    localparam int DEF_MULT_STAGES = 1;

    // Most positive value of a signed field w bits wide (w <= 64), as a raw bit pattern.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative value of a signed field w bits wide; truncate to w bits at the use site.
    function automatic logic [63:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/mac_pipe_mult.sv
// Signed DATA_W x DATA_W multiplier with MULT_STAGES output registers, an
// enable that freezes the whole pipe, a valid chain and a side-band channel
// that travels with each product. MULT_STAGES = 0 gives a combinational path.
module mac_pipe_mult #(
    parameter int DATA_W      = 8,
    parameter int MULT_STAGES = 1,
    parameter int SIDE_W      = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    input  logic                       in_valid,
    input  logic [SIDE_W-1:0]          side_in,
    output logic signed [2*DATA_W-1:0] p,
    output logic                       out_valid,
    output logic [SIDE_W-1:0]          side_out
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] prod;

    // Full-precision product; operands are sign-extended before multiplying.
    assign prod = PW'(a) * PW'(b);

    generate
        if (MULT_STAGES == 0) begin : g_comb
            assign p         = prod;
            assign out_valid = in_valid;
            assign side_out  = side_in;
        end else begin : g_pipe
            for (genvar gi = 0; gi < MULT_STAGES; gi++) begin : g_stage
                logic signed [PW-1:0] p_q;
                logic signed [PW-1:0] p_d;
                logic                 v_q;
                logic                 v_d;
                logic [SIDE_W-1:0]    s_q;
                logic [SIDE_W-1:0]    s_d;

                if (gi == 0) begin : g_first
                    assign p_d = prod;
                    assign v_d = in_valid;
                    assign s_d = side_in;
                end else begin : g_next
                    assign p_d = g_stage[gi-1].p_q;
                    assign v_d = g_stage[gi-1].v_q;
                    assign s_d = g_stage[gi-1].s_q;
                end

                // One pipeline slot; holds its contents while the datapath is stalled.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        p_q <= '0;
                        v_q <= 1'b0;
                        s_q <= '0;
                    end else if (en) begin
                        p_q <= p_d;
                        v_q <= v_d;
                        s_q <= s_d;
                    end
                end
            end

            assign p         = g_stage[MULT_STAGES-1].p_q;
            assign out_valid = g_stage[MULT_STAGES-1].v_q;
            assign side_out  = g_stage[MULT_STAGES-1].s_q;
        end
    endgenerate

endmodule

// File: rtl/mac_vec.sv
// Vector MAC: f = x + sum(a[i]*b[i]) per vector, with wrap or saturating
// accumulation, sticky per-vector overflow and valid/ready on both sides.
// A single advance enable stalls every stage while a result waits downstream.
module mac_vec
    import defines_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int MULT_STAGES = DEF_MULT_STAGES,
    parameter int VEC_MAX     = DEF_VEC_MAX,
    parameter bit SAT_EN      = 1'b0,
    localparam int LEN_W      = $clog2(VEC_MAX + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    input  logic [DATA_W-1:0]        x,
    input  logic [LEN_W-1:0]         vec_len,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [ACC_W-1:0]  f,
    output logic                     out_ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PW     = 2 * DATA_W;
    localparam int SIDE_W = DATA_W + LEN_W;
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
    localparam logic [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(VEC_MAX);

    logic adv;

    // Stage 0: captured operands
    logic signed [DATA_W-1:0] a0_q, a0_d, b0_q, b0_d;
    logic [DATA_W-1:0]        x0_q, x0_d;
    logic [LEN_W-1:0]         l0_q, l0_d;
    logic                     v0_q, v0_d;

    // Multiplier outputs
    logic signed [PW-1:0]     pm;
    logic                     vm;
    logic [SIDE_W-1:0]        sm;

    // Stage P: product register
    logic signed [PW-1:0]     d_q, d_d;
    logic [DATA_W-1:0]        xp_q, xp_d;
    logic [LEN_W-1:0]         lp_q, lp_d;
    logic                     vp_q, vp_d;

    // Accumulate stage
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [LEN_W-1:0]         cnt_q, cnt_d, len_q, len_d;
    logic                     sticky_q, sticky_d, done_q, done_d, done_ovf_q, done_ovf_d;
    logic                     first, is_last, add_ovf, vec_ovf;
    logic [LEN_W-1:0]         len_in, len_eff;
    logic [ACC_W-1:0]         op_a, op_b, sum, res;

    // Output stage
    logic signed [ACC_W-1:0]  f_q, f_d;
    logic                     out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;

    assign adv       = !(out_valid_q && !out_ready);
    assign in_ready  = adv;
    assign f         = f_q;
    assign out_ovf   = out_ovf_q;
    assign out_valid = out_valid_q;

    // Capture an element on the input handshake.
    always_comb begin
        a0_d = a0_q;
        b0_d = b0_q;
        x0_d = x0_q;
        l0_d = l0_q;
        v0_d = v0_q;
        if (adv) begin
            v0_d = in_valid;
            if (in_valid) begin
                a0_d = a;
                b0_d = b;
                x0_d = x;
                l0_d = vec_len;
            end
        end
    end

    mac_pipe_mult #(
        .DATA_W      (DATA_W),
        .MULT_STAGES (MULT_STAGES),
        .SIDE_W      (SIDE_W)
    ) u_mult (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (adv),
        .a         (a0_q),
        .b         (b0_q),
        .in_valid  (v0_q),
        .side_in   ({x0_q, l0_q}),
        .p         (pm),
        .out_valid (vm),
        .side_out  (sm)
    );

    // Register the product together with its bias and length side-band.
    always_comb begin
        d_d  = d_q;
        xp_d = xp_q;
        lp_d = lp_q;
        vp_d = vp_q;
        if (adv) begin
            vp_d = vm;
            if (vm) begin
                d_d           = pm;
                {xp_d, lp_d}  = sm;
            end
        end
    end

    // Accumulate with overflow detection; the first element seeds with the bias
    // and fixes the vector length, later vec_len values are ignored.
    always_comb begin
        first   = (cnt_q == '0);
        len_in  = (lp_q == '0) ? LEN_W'(1) : ((lp_q > LEN_MAX) ? LEN_MAX : lp_q);
        len_eff = first ? len_in : len_q;
        op_a    = first ? ACC_W'(xp_q) : acc_q;
        op_b    = ACC_W'(d_q);
        sum     = op_a + op_b;
        add_ovf = (op_a[ACC_W-1] == op_b[ACC_W-1]) && (sum[ACC_W-1] != op_a[ACC_W-1]);
        res     = sum;
        if (SAT_EN && add_ovf) begin
            res = op_a[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
        is_last = (cnt_q == len_eff - LEN_W'(1));
        vec_ovf = (!first && sticky_q) || add_ovf;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        sticky_d   = sticky_q;
        done_d     = done_q;
        done_ovf_d = done_ovf_q;
        if (adv) begin
            done_d = vp_q && is_last;
            if (vp_q) begin
                acc_d      = res;
                len_d      = len_eff;
                cnt_d      = is_last ? '0 : cnt_q + LEN_W'(1);
                sticky_d   = is_last ? 1'b0 : vec_ovf;
                done_ovf_d = vec_ovf;
            end
        end
    end

    // Present a finished vector; a new result may replace one being handed off.
    always_comb begin
        f_d         = f_q;
        out_ovf_d   = out_ovf_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            out_valid_d = done_q;
            if (done_q) begin
                f_d       = acc_q;
                out_ovf_d = done_ovf_q;
            end
        end
    end

    // State registers for all stages; reset discards any partial vector.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a0_q        <= '0;
            b0_q        <= '0;
            x0_q        <= '0;
            l0_q        <= '0;
            v0_q        <= 1'b0;
            d_q         <= '0;
            xp_q        <= '0;
            lp_q        <= '0;
            vp_q        <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            sticky_q    <= 1'b0;
            done_q      <= 1'b0;
            done_ovf_q  <= 1'b0;
            f_q         <= '0;
            out_ovf_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            a0_q        <= a0_d;
            b0_q        <= b0_d;
            x0_q        <= x0_d;
            l0_q        <= l0_d;
            v0_q        <= v0_d;
            d_q         <= d_d;
            xp_q        <= xp_d;
            lp_q        <= lp_d;
            vp_q        <= vp_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            sticky_q    <= sticky_d;
            done_q      <= done_d;
            done_ovf_q  <= done_ovf_d;
            f_q         <= f_d;
            out_ovf_q   <= out_ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
